// File: rtl/text_console_writer_pkg.sv
// -----------------------------------------------------------------------------
// text_console_writer_pkg
//   Shared constants for the text console writer: ASCII control codes,
//   printable range, default fill character, cursor widths and FSM state
//   encodings, plus a small printable-range helper.
// -----------------------------------------------------------------------------
package text_console_writer_pkg;

    // ASCII codes handled by the decoder
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Default fill code for clears
    localparam logic [7:0] SPACE_CHAR_DEF = 8'h20;

    // Cursor port widths (enough for 128 columns / 64 rows)
    localparam int COL_W = 7;
    localparam int ROW_W = 6;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PUTC     = 2'd1;
    localparam logic [1:0] ST_CLR_LINE = 2'd2;
    localparam logic [1:0] ST_CLR_ALL  = 2'd3;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// -----------------------------------------------------------------------------
// text_console_writer_if
//   Bundles the byte-stream handshake, clear request, status and character-RAM
//   write port of the text console writer.
//   master : CPU/UART side driving bytes and clear requests (also sees status)
//   slave  : the console writer itself
//   Signals:
//     in_valid/in_char/in_ready   byte stream handshake
//     clear_req                   full-screen clear request
//     busy                        writer not in IDLE
//     vc_write_enable/vc_char_in/vid_ch_addr  char RAM write port
//     cursor_col/cursor_row       current cursor position
// -----------------------------------------------------------------------------
interface text_console_writer_if #(
    parameter int ADDR_W = 13
);
    logic              in_valid;
    logic [7:0]        in_char;
    logic              in_ready;
    logic              clear_req;
    logic              busy;
    logic              vc_write_enable;
    logic [7:0]        vc_char_in;
    logic [ADDR_W-1:0] vid_ch_addr;
    logic [6:0]        cursor_col;
    logic [5:0]        cursor_row;

    modport master (
        output in_valid, in_char, clear_req,
        input  in_ready, busy, vc_write_enable, vc_char_in, vid_ch_addr,
               cursor_col, cursor_row
    );

    modport slave (
        input  in_valid, in_char, clear_req,
        output in_ready, busy, vc_write_enable, vc_char_in, vid_ch_addr,
               cursor_col, cursor_row
    );
endinterface

// File: rtl/text_console_writer_cursor.sv
// -----------------------------------------------------------------------------
// console_cursor
//   Column/row cursor with a row-base register so the linear address
//   row*COLS+col is formed without a multiplier.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     inc_i        col+1 (caller guarantees col < COLS-1)
//     nl_i         col=0, row+1 with wrap to 0 after ROWS-1
//     cr_i         col=0
//     dec_i        col-1 when col > 0
//     home_i       cursor to (0,0)
//     col_o/row_o  cursor position
//     base_o       row*COLS
//     addr_o       row*COLS+col
//   Priority when several controls are asserted: home > nl > cr > dec > inc.
// -----------------------------------------------------------------------------
module console_cursor
    import text_console_writer_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              nl_i,
    input  logic              cr_i,
    input  logic              dec_i,
    input  logic              home_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [ADDR_W-1:0] base_o,
    output logic [ADDR_W-1:0] addr_o
);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    logic [COL_W-1:0]  col_q,  col_d;
    logic [ROW_W-1:0]  row_q,  row_d;
    logic [ADDR_W-1:0] base_q, base_d;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        if (home_i) begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
        end else if (nl_i) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + ROW_W'(1);
                base_d = base_q + COLS_A;
            end
        end else if (cr_i) begin
            col_d = '0;
        end else if (dec_i) begin
            if (col_q != '0) col_d = col_q - COL_W'(1);
        end else if (inc_i) begin
            if (col_q != COL_LAST) col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign base_o = base_q;
    assign addr_o = base_q + ADDR_W'(col_q);

endmodule

// File: rtl/text_console_writer.sv
// -----------------------------------------------------------------------------
// text_console_writer
//   Sole writer of the video controller's character RAM. Accepts ASCII bytes
//   over a valid/ready stream, keeps a row/column cursor, handles LF/CR/BS,
//   and performs full-screen and single-line clears with SPACE_CHAR fills.
//   Ports:
//     clk    system clock (rising edge)
//     rst_n  asynchronous active-low reset
//     bus    text_console_writer_if.slave (stream, clear_req, status,
//            registered char RAM write port, cursor position)
// -----------------------------------------------------------------------------
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 60,
    parameter int         ADDR_W     = 13,
    parameter logic [7:0] SPACE_CHAR = SPACE_CHAR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    text_console_writer_if.slave  bus
);
    if (COLS * ROWS > (1 << ADDR_W)) begin : g_size_chk
        $error("text_console_writer: COLS*ROWS exceeds 2**ADDR_W");
    end
    if (COLS > (1 << COL_W) || ROWS > (1 << ROW_W)) begin : g_cursor_chk
        $error("text_console_writer: COLS/ROWS exceed cursor port widths");
    end

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    // Truncates to 0 when the screen fills the whole address space; the
    // done test below still works because the strobe is low on the first
    // fill cycle.
    localparam logic [ADDR_W-1:0] CELLS_A  = ADDR_W'(COLS * ROWS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fill_q,  fill_d;
    logic              we_q,    we_d;
    logic [7:0]        char_q,  char_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              bs_q,    bs_d;    // pending PUTC came from a backspace

    logic              cur_inc, cur_nl, cur_cr, cur_dec, cur_home;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [ADDR_W-1:0] cur_base, cur_addr;

    console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (cur_inc),
        .nl_i   (cur_nl),
        .cr_i   (cur_cr),
        .dec_i  (cur_dec),
        .home_i (cur_home),
        .col_o  (cur_col),
        .row_o  (cur_row),
        .base_o (cur_base),
        .addr_o (cur_addr)
    );

    // Write strobes are registered: a state loads the write for the next
    // cycle. Clears therefore spend one lead-in cycle with the strobe low
    // and finish on the cycle that presents the last write (fill counter
    // has reached the write count while the strobe is high), so the strobe
    // is never high once the FSM is back in IDLE.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        we_d     = 1'b0;
        char_d   = char_q;
        addr_d   = addr_q;
        bs_d     = bs_q;
        cur_inc  = 1'b0;
        cur_nl   = 1'b0;
        cur_cr   = 1'b0;
        cur_dec  = 1'b0;
        cur_home = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLR_ALL;
                    fill_d  = '0;
                end else if (bus.in_valid) begin
                    if (is_printable(bus.in_char)) begin
                        addr_d  = cur_addr;
                        char_d  = bus.in_char;
                        we_d    = 1'b1;
                        bs_d    = 1'b0;
                        state_d = ST_PUTC;
                    end else if (bus.in_char == CH_LF) begin
                        cur_nl  = 1'b1;
                        fill_d  = '0;
                        state_d = ST_CLR_LINE;
                    end else if (bus.in_char == CH_CR) begin
                        cur_cr = 1'b1;
                    end else if (bus.in_char == CH_BS) begin
                        if (cur_col != '0) begin
                            cur_dec = 1'b1;
                            addr_d  = cur_addr - ADDR_W'(1);
                            char_d  = SPACE_CHAR;
                            we_d    = 1'b1;
                            bs_d    = 1'b1;
                            state_d = ST_PUTC;
                        end
                    end
                end
            end

            ST_PUTC: begin
                if (bs_q) begin
                    state_d = ST_IDLE;
                end else if (cur_col == COL_LAST) begin
                    cur_nl  = 1'b1;
                    fill_d  = '0;
                    state_d = ST_CLR_LINE;
                end else begin
                    cur_inc = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_CLR_LINE: begin
                if (we_q && (fill_q == COLS_A)) begin
                    fill_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cur_base + fill_q;
                    char_d = SPACE_CHAR;
                    fill_d = fill_q + ADDR_W'(1);
                end
            end

            default: begin  // ST_CLR_ALL
                if (we_q && (fill_q == CELLS_A)) begin
                    fill_d   = '0;
                    cur_home = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = fill_q;
                    char_d = SPACE_CHAR;
                    fill_d = fill_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLR_ALL;
            fill_q  <= '0;
            we_q    <= 1'b0;
            char_q  <= '0;
            addr_q  <= '0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            we_q    <= we_d;
            char_q  <= char_d;
            addr_q  <= addr_d;
            bs_q    <= bs_d;
        end
    end

    assign bus.in_ready        = (state_q == ST_IDLE) && !bus.clear_req;
    assign bus.busy            = (state_q != ST_IDLE);
    assign bus.vc_write_enable = we_q;
    assign bus.vc_char_in      = char_q;
    assign bus.vid_ch_addr     = addr_q;
    assign bus.cursor_col      = cur_col;
    assign bus.cursor_row      = cur_row;

endmodule

// File: tb/tb_text_console_writer.sv
// -----------------------------------------------------------------------------
// tb_text_console_writer
//   Directed bench for text_console_writer (80x60, 13-bit address). A monitor
//   logs every char RAM write strobe; tests compare the log and cursor against
//   hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_text_console_writer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_console_writer_if #(.ADDR_W(13)) bus ();

    text_console_writer #(
        .COLS       (80),
        .ROWS       (60),
        .ADDR_W     (13),
        .SPACE_CHAR (8'h20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wq[$];
    int  n_run  = 0;
    int  n_fail = 0;

    always @(negedge clk)
        if (bus.vc_write_enable === 1'b1)
            wq.push_back('{a: bus.vid_ch_addr, d: bus.vc_char_in});

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) chk(tag, bus.busy, 0);
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) chk("ready_tmo", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_idle("send_tmo", 200);
    endtask

    task automatic clear_screen();
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        wait_idle("clr_tmo", 6000);
    endtask

    // Counts log entries in [lo,hi) whose address != base+i-lo or data != d
    function automatic int bad_run(int lo, int hi, int base, int d);
        int bad = 0;
        for (int i = lo; i < hi; i++)
            if (i >= wq.size() || int'(wq[i].a) != base + i - lo || int'(wq[i].d) != d)
                bad++;
        return bad;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.clear_req = 1'b0;

        // ---- 1: reset state and power-up clear
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  bus.busy, 1);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we",    bus.vc_write_enable, 0);
        chk("rst_addr",  bus.vid_ch_addr, 0);
        chk("rst_data",  bus.vc_char_in, 0);
        chk("rst_col",   bus.cursor_col, 0);
        chk("rst_row",   bus.cursor_row, 0);
        rst_n = 1'b1;
        wq.delete();
        wait_idle("pwrup_tmo", 6000);
        chk("pwrup_cnt",   wq.size(), 4800);
        chk("pwrup_order", bad_run(0, 4800, 0, 8'h20), 0);
        chk("pwrup_busy",  bus.busy, 0);
        chk("pwrup_ready", bus.in_ready, 1);

        // ---- 2: 'A','B' at (0,0)
        wq.delete();
        send(8'h41);
        send(8'h42);
        chk("ab_cnt", wq.size(), 2);
        chk("ab_a0",  wq.size() > 0 ? int'(wq[0].a) : -1, 0);
        chk("ab_d0",  wq.size() > 0 ? int'(wq[0].d) : -1, 8'h41);
        chk("ab_a1",  wq.size() > 1 ? int'(wq[1].a) : -1, 1);
        chk("ab_d1",  wq.size() > 1 ? int'(wq[1].d) : -1, 8'h42);
        chk("ab_col", bus.cursor_col, 2);
        chk("ab_row", bus.cursor_row, 0);

        // ---- 3: 81 printables from (0,0), wrap with row-1 clear
        clear_screen();
        chk("home_col", bus.cursor_col, 0);
        wq.delete();
        for (int k = 0; k < 81; k++) send(8'(8'h21 + k));
        chk("wrap_cnt", wq.size(), 161);
        bad = 0;
        for (int i = 0; i < 80 && i < wq.size(); i++)
            if (int'(wq[i].a) != i || int'(wq[i].d) != 8'h21 + i) bad++;
        chk("wrap_row0",  bad, 0);
        chk("wrap_clr1",  bad_run(80, 160, 80, 8'h20), 0);
        chk("wrap_c81_a", wq.size() > 160 ? int'(wq[160].a) : -1, 80);
        chk("wrap_c81_d", wq.size() > 160 ? int'(wq[160].d) : -1, 8'h71);
        chk("wrap_col",   bus.cursor_col, 1);
        chk("wrap_row",   bus.cursor_row, 1);

        // ---- 4: LF at last row wraps to row 0 with clear; CR
        for (int k = 0; k < 58; k++) send(8'h0A);
        chk("lf59_row", bus.cursor_row, 59);
        chk("lf59_col", bus.cursor_col, 0);
        wq.delete();
        send(8'h0A);
        chk("lfw_row", bus.cursor_row, 0);
        chk("lfw_col", bus.cursor_col, 0);
        chk("lfw_cnt", wq.size(), 80);
        chk("lfw_clr", bad_run(0, 80, 0, 8'h20), 0);
        for (int k = 0; k < 5; k++)  send(8'h0A);
        for (int k = 0; k < 10; k++) send(8'h78);
        chk("pos_row", bus.cursor_row, 5);
        chk("pos_col", bus.cursor_col, 10);
        wq.delete();
        send(8'h0D);
        chk("cr_cnt", wq.size(), 0);
        chk("cr_col", bus.cursor_col, 0);
        chk("cr_row", bus.cursor_row, 5);

        // ---- 5: backspace and dropped control code
        clear_screen();
        for (int k = 0; k < 3; k++) send(8'h0A);
        wq.delete();
        send(8'h08);
        chk("bs0_cnt", wq.size(), 0);
        chk("bs0_col", bus.cursor_col, 0);
        chk("bs0_row", bus.cursor_row, 3);
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        wq.delete();
        send(8'h08);
        chk("bs_cnt",  wq.size(), 1);
        chk("bs_addr", wq.size() > 0 ? int'(wq[0].a) : -1, 243);
        chk("bs_data", wq.size() > 0 ? int'(wq[0].d) : -1, 8'h20);
        chk("bs_col",  bus.cursor_col, 3);
        chk("bs_row",  bus.cursor_row, 3);
        wq.delete();
        send(8'h07);
        chk("bel_cnt", wq.size(), 0);
        chk("bel_col", bus.cursor_col, 3);

        // ---- 6a: clear_req beats a same-cycle char
        wq.delete();
        @(posedge clk); #1;
        bus.clear_req = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_char   = 8'h5A;
        #1;
        chk("prio_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        bus.in_valid  = 1'b0;
        chk("prio_busy", bus.busy, 1);
        wait_idle("prio_tmo", 6000);
        chk("prio_cnt", wq.size(), 4800);
        chk("prio_all", bad_run(0, 4800, 0, 8'h20), 0);
        chk("prio_col", bus.cursor_col, 0);
        chk("prio_row", bus.cursor_row, 0);

        // ---- 6b: reset mid-clear aborts and restarts from address 0
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_we", bus.vc_write_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_we",   bus.vc_write_enable, 0);
        chk("abort_addr", bus.vid_ch_addr, 0);
        chk("abort_busy", bus.busy, 1);
        wq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle("rerst_tmo", 6000);
        chk("rerst_cnt",   wq.size(), 4800);
        chk("rerst_first", wq.size() > 0 ? int'(wq[0].a) : -1, 0);
        chk("rerst_order", bad_run(0, 4800, 0, 8'h20), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
